// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants and the immediate-format selector.
package rv32i_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator; the opcode bits are not needed so they are not passed in.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_type_e   imm_type,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode / operand-fetch stage: decode, operand forwarding, load-use stall, ID/EX register.
module id_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_pc,
  input  logic [31:0]     if_instr,
  input  logic            flush,
  output logic            id_stall,
  output logic [4:0]      rs1_src,
  output logic [4:0]      rs2_src,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      ex_rd_src,
  input  logic [4:0]      mem_rd_src,
  input  logic [4:0]      wb_rd_src,
  input  logic            ex_reg_we,
  input  logic            mem_reg_we,
  input  logic            wb_reg_we,
  input  logic            ex_is_load,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] mem_result,
  input  logic [XLEN-1:0] wb_result,
  output logic            id_valid,
  output logic [31:0]     id_pc,
  output logic [XLEN-1:0] id_rs1_val,
  output logic [XLEN-1:0] id_rs2_val,
  output logic [31:0]     id_imm,
  output logic [4:0]      id_rd_src,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
  output logic            id_funct7b5,
  output logic            id_reg_we,
  output logic            id_is_load,
  output logic            id_illegal
);

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic            uses_rs1, uses_rs2;
  logic            writes_rd, is_load, illegal;
  imm_type_e       imm_type;
  logic [31:0]     imm;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic            load_use, capture;

  assign opcode  = if_instr[6:0];
  assign rd      = if_instr[11:7];
  assign rs1_src = if_instr[19:15];
  assign rs2_src = if_instr[24:20];

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    illegal   = 1'b0;
    imm_type  = IMM_NONE;
    case (opcode)
      OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_IMM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        imm_type  = IMM_I;
      end
      LOAD: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        is_load   = 1'b1;
        imm_type  = IMM_I;
      end
      STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm_type = IMM_S;
      end
      BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm_type = IMM_B;
      end
      LUI, AUIPC: begin
        writes_rd = 1'b1;
        imm_type  = IMM_U;
      end
      JAL: begin
        writes_rd = 1'b1;
        imm_type  = IMM_J;
      end
      JALR: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        imm_type  = IMM_I;
      end
      default: illegal = 1'b1;
    endcase
  end

  imm_gen u_imm_gen (
    .instr    (if_instr[31:7]),
    .imm_type (imm_type),
    .imm      (imm)
  );

  // EX is skipped for loads (data not ready); WB must win over the regfile, which is stale.
  function automatic logic [XLEN-1:0] fwd(input logic [4:0] addr, input logic [XLEN-1:0] rf_val);
    logic [XLEN-1:0] val;
    if (addr == 5'd0) begin
      val = '0;
    end else if (ex_reg_we && !ex_is_load && ex_rd_src == addr) begin
      val = ex_result;
    end else if (mem_reg_we && mem_rd_src == addr) begin
      val = mem_result;
    end else if (wb_reg_we && wb_rd_src == addr) begin
      val = wb_result;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  always_comb begin
    rs1_fwd = fwd(rs1_src, rs1);
    rs2_fwd = fwd(rs2_src, rs2);
  end

  assign load_use = if_valid && ex_is_load && ex_reg_we && (ex_rd_src != 5'd0) &&
                    ((uses_rs1 && ex_rd_src == rs1_src) || (uses_rs2 && ex_rd_src == rs2_src));
  assign id_stall = load_use && !flush && !rst;
  assign capture  = if_valid && !flush && !load_use;

  // Bubbles clear only the control bits; pc and data fields keep their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid    <= 1'b0;
      id_pc       <= RESET_PC;
      id_rs1_val  <= '0;
      id_rs2_val  <= '0;
      id_imm      <= '0;
      id_rd_src   <= '0;
      id_opcode   <= '0;
      id_funct3   <= '0;
      id_funct7b5 <= 1'b0;
      id_reg_we   <= 1'b0;
      id_is_load  <= 1'b0;
      id_illegal  <= 1'b0;
    end else if (capture) begin
      id_valid    <= 1'b1;
      id_pc       <= if_pc;
      id_rs1_val  <= rs1_fwd;
      id_rs2_val  <= rs2_fwd;
      id_imm      <= imm;
      id_rd_src   <= rd;
      id_opcode   <= opcode;
      id_funct3   <= if_instr[14:12];
      id_funct7b5 <= if_instr[30];
      id_reg_we   <= writes_rd && (rd != 5'd0);
      id_is_load  <= is_load;
      id_illegal  <= illegal;
    end else begin
      id_valid   <= 1'b0;
      id_reg_we  <= 1'b0;
      id_is_load <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed, table-driven bench for id_stage plus hand sequences for load-use and async reset.
module tb_id_stage;

  localparam logic [31:0] RPC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, flush;
  logic [31:0] if_pc, if_instr;
  logic        id_stall;
  logic [4:0]  rs1_src, rs2_src;
  logic [31:0] rs1, rs2;
  logic [4:0]  ex_rd_src, mem_rd_src, wb_rd_src;
  logic        ex_reg_we, mem_reg_we, wb_reg_we, ex_is_load;
  logic [31:0] ex_result, mem_result, wb_result;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]  id_rd_src;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7b5, id_reg_we, id_is_load, id_illegal;

  always #5 clk = ~clk;

  id_stage #(
    .XLEN     (32),
    .RESET_PC (RPC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .flush       (flush),
    .id_stall    (id_stall),
    .rs1_src     (rs1_src),
    .rs2_src     (rs2_src),
    .rs1         (rs1),
    .rs2         (rs2),
    .ex_rd_src   (ex_rd_src),
    .mem_rd_src  (mem_rd_src),
    .wb_rd_src   (wb_rd_src),
    .ex_reg_we   (ex_reg_we),
    .mem_reg_we  (mem_reg_we),
    .wb_reg_we   (wb_reg_we),
    .ex_is_load  (ex_is_load),
    .ex_result   (ex_result),
    .mem_result  (mem_result),
    .wb_result   (wb_result),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_rs1_val  (id_rs1_val),
    .id_rs2_val  (id_rs2_val),
    .id_imm      (id_imm),
    .id_rd_src   (id_rd_src),
    .id_opcode   (id_opcode),
    .id_funct3   (id_funct3),
    .id_funct7b5 (id_funct7b5),
    .id_reg_we   (id_reg_we),
    .id_is_load  (id_is_load),
    .id_illegal  (id_illegal)
  );

  typedef struct {
    logic [31:0] instr, pc, ifv, flush, rf1, rf2;
    logic [31:0] exrd, exwe, exld, exres;
    logic [31:0] memrd, memwe, memres;
    logic [31:0] wbrd, wbwe, wbres;
    logic [31:0] stall, bub, rs1v, rs2v, imm, rd, we, ld, ill;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  int checks = 0;
  int failures = 0;
  logic [31:0] last_pc, last_rs1, last_imm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if_instr   = v.instr;
    if_pc      = v.pc;
    if_valid   = v.ifv[0];
    flush      = v.flush[0];
    rs1        = v.rf1;
    rs2        = v.rf2;
    ex_rd_src  = v.exrd[4:0];
    ex_reg_we  = v.exwe[0];
    ex_is_load = v.exld[0];
    ex_result  = v.exres;
    mem_rd_src = v.memrd[4:0];
    mem_reg_we = v.memwe[0];
    mem_result = v.memres;
    wb_rd_src  = v.wbrd[4:0];
    wb_reg_we  = v.wbwe[0];
    wb_result  = v.wbres;
  endtask

  initial begin
    // instr, pc, ifv, flush, rf1, rf2 | ex rd,we,ld,res | mem rd,we,res | wb rd,we,res |
    // stall, bubble, rs1v, rs2v, imm, rd, reg_we, is_load, illegal
    vecs[0]  = '{'hFFF00293, 'h100, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 'hFFFFFFFF, 5, 1, 0, 0};
    vecs[1]  = '{'h002081B3, 'h104, 1, 0, 10, 20, 0, 0, 0, 0, 1, 1, 7, 2, 1, 9,
                 0, 0, 7, 9, 0, 3, 1, 0, 0};
    vecs[2]  = '{'h002081B3, 'h108, 1, 0, 10, 20, 1, 1, 0, 3, 1, 1, 7, 2, 1, 9,
                 0, 0, 3, 9, 0, 3, 1, 0, 0};
    vecs[3]  = '{'h00012203, 'h10C, 1, 0, 'h1000, 'h999, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 'h1000, 0, 0, 4, 1, 1, 0};
    vecs[4]  = '{'h40120333, 'h110, 1, 0, 1, 2, 4, 1, 1, 'hBAD, 0, 0, 0, 0, 0, 0,
                 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{'h40120333, 'h110, 1, 1, 1, 2, 4, 1, 1, 'hBAD, 0, 0, 0, 0, 0, 0,
                 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{'h40120333, 'h110, 0, 0, 1, 2, 4, 1, 1, 'hBAD, 0, 0, 0, 0, 0, 0,
                 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{'h00500093, 'h114, 1, 0, 'h77, 'h5555, 0, 1, 0, 'hDEAD, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 'h5555, 5, 1, 1, 0, 0};
    vecs[8]  = '{'hFE208EE3, 'h118, 1, 0, 'h11, 'h22, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 'h11, 'h22, 'hFFFFFFFC, 29, 0, 0, 0};
    vecs[9]  = '{'h0000007F, 'h11C, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[10] = '{'h123453B7, 'h120, 1, 0, 'h88, 'h33, 8, 1, 1, 'hF00, 0, 0, 0, 0, 0, 0,
                 0, 0, 'h88, 'h33, 'h12345000, 7, 1, 0, 0};
    vecs[11] = '{'h0020A423, 'h124, 1, 0, 'h2000, 1, 0, 0, 0, 0, 2, 0, 'hEE, 2, 1, 'hAB,
                 0, 0, 'h2000, 'hAB, 8, 8, 0, 0, 0};
    vecs[12] = '{'h008000EF, 'h128, 1, 0, 0, 'h42, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 'h42, 8, 1, 1, 0, 0};
    vecs[13] = '{'h00500093, 'h12C, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 5, 1, 1, 0, 0};
    vecs[14] = '{'h002081B3, 'h130, 1, 0, 10, 20, 0, 0, 0, 0, 1, 1, 7, 1, 1, 9,
                 0, 0, 7, 20, 0, 3, 1, 0, 0};

    rst = 1'b1;
    drive('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    #2;
    chk("reset id_valid", 32'(id_valid), 0);
    chk("reset id_pc", id_pc, RPC);
    chk("reset id_imm", id_imm, 0);
    chk("reset id_rs1_val", id_rs1_val, 0);
    chk("reset id_reg_we", 32'(id_reg_we), 0);
    last_pc  = RPC;
    last_rs1 = 0;
    last_imm = 0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d id_stall", i), 32'(id_stall), vecs[i].stall);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d id_valid", i), 32'(id_valid), vecs[i].bub ^ 1);
      chk($sformatf("v%0d id_reg_we", i), 32'(id_reg_we), vecs[i].we);
      chk($sformatf("v%0d id_is_load", i), 32'(id_is_load), vecs[i].ld);
      if (vecs[i].bub[0]) begin
        chk($sformatf("v%0d held id_pc", i), id_pc, last_pc);
        chk($sformatf("v%0d held id_rs1_val", i), id_rs1_val, last_rs1);
        chk($sformatf("v%0d held id_imm", i), id_imm, last_imm);
      end else begin
        chk($sformatf("v%0d id_pc", i), id_pc, vecs[i].pc);
        chk($sformatf("v%0d id_rs1_val", i), id_rs1_val, vecs[i].rs1v);
        chk($sformatf("v%0d id_rs2_val", i), id_rs2_val, vecs[i].rs2v);
        chk($sformatf("v%0d id_imm", i), id_imm, vecs[i].imm);
        chk($sformatf("v%0d id_rd_src", i), 32'(id_rd_src), vecs[i].rd);
        chk($sformatf("v%0d id_illegal", i), 32'(id_illegal), vecs[i].ill);
        last_pc  = vecs[i].pc;
        last_rs1 = vecs[i].rs1v;
        last_imm = vecs[i].imm;
      end
    end

    // lw x4 in EX, sub x6,x4,x1 at fetch: one stall, then MEM forwarding on the retry
    @(negedge clk);
    drive('{'h40120333, 'h134, 1, 0, 0, 'h77, 4, 1, 1, 'hBAD, 0, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 0, 0, 0});
    #1;
    chk("lu stall cycle1", 32'(id_stall), 1);
    @(posedge clk);
    #1;
    chk("lu bubble id_valid", 32'(id_valid), 0);
    @(negedge clk);
    drive('{'h40120333, 'h134, 1, 0, 0, 'h77, 0, 0, 0, 0, 4, 1, 'h55, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 0, 0, 0});
    #1;
    chk("lu stall cycle2", 32'(id_stall), 0);
    @(posedge clk);
    #1;
    chk("lu id_valid", 32'(id_valid), 1);
    chk("lu id_rs1_val", id_rs1_val, 'h55);
    chk("lu id_rs2_val", id_rs2_val, 'h77);
    chk("lu id_rd_src", 32'(id_rd_src), 6);
    chk("lu id_funct7b5", 32'(id_funct7b5), 1);
    chk("lu id_pc", id_pc, 'h134);

    // Asynchronous reset between edges, with a load-use pattern still presented
    @(negedge clk);
    drive('{'h40120333, 'h138, 1, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 0, 0, 0});
    #2;
    rst = 1'b1;
    #1;
    chk("async rst id_valid", 32'(id_valid), 0);
    chk("async rst id_pc", id_pc, RPC);
    chk("async rst id_stall", 32'(id_stall), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode / operand-fetch pipeline stage of the rv32i core; sits between fetch and execute.
- Drives the register-file read addresses and receives the read data combinationally in the same cycle.
- Forwards in-flight results from EX/MEM/WB, detects load-use hazards and registers a decoded bundle into the ID/EX pipeline register.

Parameters:
- XLEN, 32, datapath width
- RESET_PC, 32'h0000_0000, value loaded into id_pc on reset

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- if_valid  in  1  fetch presents a valid instruction
- if_pc  in  32  PC of fetched instruction
- if_instr  in  32  fetched instruction word
- flush  in  1  branch/jump redirect from EX; kill the instruction currently in ID
- id_stall  out  1  fetch must hold if_pc/if_instr this cycle (combinational)
- rs1_src  out  5  register-file read address 1 (combinational from if_instr)
- rs2_src  out  5  register-file read address 2
- rs1  in  32  register-file read data 1
- rs2  in  32  register-file read data 2
- ex_rd_src, mem_rd_src, wb_rd_src  in  5 each  destination of instruction in EX/MEM/WB
- ex_reg_we, mem_reg_we, wb_reg_we  in  1 each  that instruction writes rd
- ex_is_load  in  1  instruction in EX is a load
- ex_result, mem_result, wb_result  in  32 each  forwardable values
- id_valid  out  1  ID/EX register holds a live instruction
- id_pc  out  32  registered PC
- id_rs1_val, id_rs2_val  out  32 each  forwarded operands
- id_imm  out  32  sign-extended immediate
- id_rd_src  out  5  destination register
- id_opcode  out  7; id_funct3  out  3; id_funct7b5  out  1
- id_reg_we  out  1  rd write enable (0 when rd==x0)
- id_is_load  out  1  instruction is a load
- id_illegal  out  1  unsupported opcode

Behaviour:
- Reset (async, rst=1): id_valid=0, id_pc=RESET_PC, all other registered outputs 0; id_stall=0 while rst=1.
- Latency 1: fields decoded from if_instr in cycle N appear on id_* after posedge N.
- rs1_src=if_instr[19:15], rs2_src=if_instr[24:20], always driven regardless of opcode.
- Operand usage: LUI/AUIPC/JAL use none; OP-IMM/LOAD/JALR use rs1; OP/STORE/BRANCH use rs1 and rs2.
- Forwarding per operand, priority EX > MEM > WB > regfile; a source matches only if its reg_we=1, its rd_src equals the operand address, and the address is nonzero. x0 always yields 0.
- EX forwarding is illegal when ex_is_load=1 (value not yet available); that case is the hazard below.
- WB forwarding is mandatory: the register file commits on the same edge as the ID/EX capture, so its read data is stale.
- Load-use hazard: if_valid & ex_is_load & ex_reg_we & ex_rd_src!=0 & ex_rd_src matches a used operand → id_stall=1, and the next edge loads a bubble (id_valid=0, id_reg_we=0, id_is_load=0). The instruction stays at fetch and re-decodes next cycle with MEM forwarding.
- flush=1 takes precedence over stall: id_stall=0, bubble captured next edge.
- if_valid=0: bubble captured, id_stall=0.
- Bubbles hold id_pc and data outputs at their previous values; only control bits clear.
- id_imm formats:
  - I: instr[31:20] sign-extended
  - S: {instr[31:25],instr[11:7]}
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}
  - U: instr[31:12]<<12
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}
  - R-type: imm=0
- id_reg_we=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR when rd!=0. Unknown opcode: id_illegal=1, id_reg_we=0, id_valid still 1.

Decomposition:
- Shared package rv32i_pkg: opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR), imm_type_e enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}.
- One sub-module imm_gen: combinational, instr + imm_type_e → 32-bit imm.
- Forwarding muxes and hazard logic live in id_stage.

Test Plan:
- Reset mid-run: assert rst asynchronously between edges → id_valid=0 and id_pc=RESET_PC immediately, no clock required.
- addi x5,x0,-1 (0xFFF00293), no hazards → next cycle id_imm=0xFFFFFFFF, id_rd_src=5, id_reg_we=1, id_rs1_val=0.
- add x3,x1,x2 with rs1=10, rs2=20; MEM writes x1=7 and WB writes x2=9 → id_rs1_val=7, id_rs2_val=9. Repeat with EX also writing x1=3 → id_rs1_val=3.
- lw x4 in EX, sub x6,x4,x1 at fetch → id_stall=1 for one cycle and a bubble is captured; next cycle load in MEM with mem_result=0x55 → id_rs1_val=0x55, id_stall=0.
- Same load-use case with flush=1 → id_stall=0 and a bubble is captured. Writer to x0 in EX with ex_result=0xDEAD → id_rs1_val=0.
- beq (0xFE208EE3) → id_imm=0xFFFFFFFC. Unknown opcode 0x7F → id_illegal=1, id_reg_we=0.
